// File: rtl/bypass_add_sequencer.sv
// Multi-precision adder sequencer: streams WORDS 16-bit slices (LSW first) through one external adder.
// Optional subtract mode (in_sub) is compiled in with `define BYPASS_SEQ_SUB_EN.
module bypass_add_sequencer #(
  parameter int WORDS = 4,
  parameter int SW    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORDS*SW-1:0] in_a,
  input  logic [WORDS*SW-1:0] in_b,
  input  logic                in_cin,
`ifdef BYPASS_SEQ_SUB_EN
  input  logic                in_sub,
`endif
  output logic [SW-1:0]       add_a,
  output logic [SW-1:0]       add_b,
  output logic                add_cin,
  input  logic [SW-1:0]       add_sum,
  input  logic                add_cout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDS*SW-1:0] out_sum,
  output logic                out_cout,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  localparam int IW = $clog2(WORDS);

  if (SW != 16 || WORDS < 2 || WORDS > 16) begin : g_bad_param
    $error("bypass_add_sequencer: SW must be 16 and WORDS in 2..16");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state;
  logic [IW-1:0]       idx;
  logic                carry_q;
  logic [WORDS*SW-1:0] op_a;
  logic [WORDS*SW-1:0] op_b;
  logic [SW-1:0]       b_slice;
  logic                last;
`ifdef BYPASS_SEQ_SUB_EN
  logic                sub_q;
`endif

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and in_ready/out_valid are driven purely from FSM state.
  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;
  assign last      = (idx == IW'(WORDS - 1));
  assign b_slice   = op_b[idx*SW +: SW];

  // Adder is only driven during RUN so it sees no activity while idle or holding a result.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == S_RUN) begin
      add_a   = op_a[idx*SW +: SW];
`ifdef BYPASS_SEQ_SUB_EN
      add_b   = sub_q ? ~b_slice : b_slice;
`else
      add_b   = b_slice;
`endif
      add_cin = carry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      carry_q   <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_valid <= 1'b0;
`ifdef BYPASS_SEQ_SUB_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_a  <= in_a;
            op_b  <= in_b;
            idx   <= '0;
            state <= S_RUN;
`ifdef BYPASS_SEQ_SUB_EN
            sub_q   <= in_sub;
            carry_q <= in_sub ? 1'b1 : in_cin;
`else
            carry_q <= in_cin;
`endif
          end
        end
        S_RUN: begin
          out_sum[idx*SW +: SW] <= add_sum;
          carry_q               <= add_cout;
          if (last) begin
            // Final carry leaves on out_cout only; it is never recirculated into slice 0.
            out_cout  <= add_cout;
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
